// File: rtl/conv1_mac_pipe_mul.sv
// Pipelined multiply-accumulate for the Conv1 datapath: operand pairs go through a
// NUM_STAGE product pipeline and are summed per first/last group, one result per group.
module conv1_mac_pipe_mul #(
  parameter int DIN0_WIDTH  = 8,
  parameter int DIN1_WIDTH  = 8,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 3,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  ovf
);

  localparam int P           = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit PROD_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} grp_state_t;

  grp_state_t             state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic                   ovf_acc_reg, ovf_acc_next;
  logic [ACC_WIDTH-1:0]   dout_reg, dout_next;
  logic                   ovf_reg, ovf_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   en;

  // A result waiting on a stalled consumer freezes the whole datapath.
  assign en       = !(out_valid_reg && !out_ready);
  assign in_ready = en;

  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [P-1:0]        prod_in;

  assign a_ext   = {((DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0), din0};
  assign b_ext   = {((DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0), din1};
  // The low P bits of the product do not depend on how far the operands are extended.
  assign prod_in = P'(a_ext) * P'(b_ext);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      logic [P-1:0] prod_reg;
      logic         valid_reg;
      logic         first_reg;
      logic         last_reg;
      logic [P-1:0] prod_src;
      logic         valid_src;
      logic         first_src;
      logic         last_src;

      if (gi == 0) begin : g_head
        assign prod_src  = prod_in;
        assign valid_src = in_valid;
        assign first_src = in_first;
        assign last_src  = in_last;
      end else begin : g_body
        assign prod_src  = g_stage[gi-1].prod_reg;
        assign valid_src = g_stage[gi-1].valid_reg;
        assign first_src = g_stage[gi-1].first_reg;
        assign last_src  = g_stage[gi-1].last_reg;
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          prod_reg  <= '0;
          valid_reg <= 1'b0;
          first_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (en) begin
          prod_reg  <= prod_src;
          valid_reg <= valid_src;
          first_reg <= first_src;
          last_reg  <= last_src;
        end
      end
    end
  endgenerate

  logic [P-1:0] tail_prod;
  logic         tail_valid;
  logic         tail_first;
  logic         tail_last;

  assign tail_prod  = g_stage[NUM_STAGE-1].prod_reg;
  assign tail_valid = g_stage[NUM_STAGE-1].valid_reg;
  assign tail_first = g_stage[NUM_STAGE-1].first_reg;
  assign tail_last  = g_stage[NUM_STAGE-1].last_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_acc_reg   <= 1'b0;
      dout_reg      <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_acc_reg   <= ovf_acc_next;
      dout_reg      <= dout_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
    end
  end

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_ovf;
  logic                 treat_first;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_acc_next   = ovf_acc_reg;
    dout_next      = dout_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    treat_first    = tail_first || (state_reg == IDLE);

    // Mixed/signed products fit P bits as signed; unsigned-only products are non-negative.
    if (PROD_SIGNED) prod_ext = ACC_WIDTH'($signed(tail_prod));
    else             prod_ext = ACC_WIDTH'(tail_prod);

    sum     = acc_reg + prod_ext;
    add_ovf = (acc_reg[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

    if (out_valid_reg && out_ready) out_valid_next = 1'b0;

    if (en && tail_valid) begin
      if (treat_first) begin
        acc_next     = prod_ext;
        ovf_acc_next = 1'b0;
      end else begin
        acc_next     = sum;
        ovf_acc_next = ovf_acc_reg || add_ovf;
      end
      if (tail_last) begin
        dout_next      = acc_next;
        ovf_next       = ovf_acc_next;
        out_valid_next = 1'b1;
        state_next     = IDLE;
      end else begin
        state_next     = ACC;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_conv1_mac_pipe_mul.sv
// Bench for conv1_mac_pipe_mul: directed scenarios on three parameterisations plus a
// randomized stream checked against an arithmetic group-sum model.
module tb_conv1_mac_pipe_mul;

  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default parameterisation
  logic        v0, r0, f0, l0, ov0, or0, ovf0;
  logic [7:0]  a0, b0;
  logic [31:0] d0;
  // both operands unsigned
  logic        v1, r1, f1, l1, ov1, or1, ovf1;
  logic [7:0]  a1, b1;
  logic [31:0] d1;
  // 16-bit accumulator
  logic        v2, r2, f2, l2, ov2, or2, ovf2;
  logic [7:0]  a2, b2;
  logic [15:0] d2;

  conv1_mac_pipe_mul u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v0), .in_ready(r0), .din0(a0), .din1(b0),
    .in_first(f0), .in_last(l0), .out_valid(ov0), .out_ready(or0), .dout(d0), .ovf(ovf0));

  conv1_mac_pipe_mul #(.DIN1_SIGNED(0)) u_uns (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v1), .in_ready(r1), .din0(a1), .din1(b1),
    .in_first(f1), .in_last(l1), .out_valid(ov1), .out_ready(or1), .dout(d1), .ovf(ovf1));

  conv1_mac_pipe_mul #(.ACC_WIDTH(16)) u_a16 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v2), .in_ready(r2), .din0(a2), .din1(b2),
    .in_first(f2), .in_last(l2), .out_valid(ov2), .out_ready(or2), .dout(d2), .ovf(ovf2));

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    int guard;
    guard = 0;
    v0 = 1'b1; a0 = a; b0 = b; f0 = f; l0 = l;
    @(negedge clk);
    while (!r0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL send0_accept: in_ready=%b required 1 within 50 cycles", r0);
    end
    @(posedge clk); #1;
    v0 = 1'b0; f0 = 1'b0; l0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    v1 = 1'b1; a1 = a; b1 = b; f1 = f; l1 = l;
    @(posedge clk); #1;
    v1 = 1'b0; f1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    v2 = 1'b1; a2 = a; b2 = b; f2 = f; l2 = l;
    @(posedge clk); #1;
    v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
  endtask

  task automatic wait_ov0(output int cyc);
    cyc = 0;
    while (!ov0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_ov1();
    int cyc;
    cyc = 0;
    while (!ov1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_ov2();
    int cyc;
    cyc = 0;
    while (!ov2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", r0); end
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", ov0); end
    n_checks++; if (d0 !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %0h required 0", d0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf0); end
    n_checks++; if (d2 !== 16'd0 || ov2 !== 1'b0) begin n_fail++; $display("FAIL reset_a16: dout=%0h valid=%b required 0/0", d2, ov2); end
    @(posedge clk); #1;
  endtask

  task automatic test_group4();
    int cyc;
    or0 = 1'b1;
    send0(8'd10, 8'd1, 1'b1, 1'b0);
    send0(8'd20, 8'hFE, 1'b0, 1'b0);
    send0(8'd30, 8'd3, 1'b0, 1'b0);
    send0(8'd40, 8'hFC, 1'b0, 1'b1);
    wait_ov0(cyc);
    n_checks++; if (cyc !== NS) begin n_fail++; $display("FAIL group4_latency: %0d edges after accept, required %0d", cyc, NS); end
    n_checks++; if (d0 !== 32'hFFFF_FF9C) begin n_fail++; $display("FAIL group4_dout: got %0d required -100", $signed(d0)); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL group4_ovf: got %b required 0", ovf0); end
    $display("group4: dout=%0d ovf=%0b latency=%0d", $signed(d0), ovf0, cyc);
    @(posedge clk); #1;
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL group4_valid_clear: got %b required 0", ov0); end
  endtask

  task automatic test_unsigned();
    or1 = 1'b1;
    send1(8'd255, 8'd255, 1'b1, 1'b1);
    wait_ov1();
    n_checks++; if (ov1 !== 1'b1 || d1 !== 32'd65025) begin n_fail++; $display("FAIL unsigned_dout: valid=%b dout=%0d required 1/65025", ov1, d1); end
    n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL unsigned_ovf: got %b required 0", ovf1); end
    $display("unsigned: dout=%0d ovf=%0b", d1, ovf1);
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    or2 = 1'b1;
    send2(8'd127, 8'd127, 1'b1, 1'b0);
    send2(8'd127, 8'd127, 1'b0, 1'b1);
    wait_ov2();
    n_checks++; if (d2 !== 16'd32258 || ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovf_two: dout=%0d ovf=%b required 32258/0", $signed(d2), ovf2); end
    $display("ovf two beats: dout=%0d ovf=%0b", $signed(d2), ovf2);
    @(posedge clk); #1;
    send2(8'd127, 8'd127, 1'b1, 1'b0);
    send2(8'd127, 8'd127, 1'b0, 1'b0);
    send2(8'd127, 8'd127, 1'b0, 1'b1);
    wait_ov2();
    n_checks++; if (d2 !== 16'hBD03) begin n_fail++; $display("FAIL ovf_wrap_dout: got %0d required -17149", $signed(d2)); end
    n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_flag: got %b required 1", ovf2); end
    $display("ovf three beats: dout=%0d ovf=%0b", $signed(d2), ovf2);
    @(posedge clk); #1;
    send2(8'd2, 8'd3, 1'b1, 1'b1);
    wait_ov2();
    n_checks++; if (d2 !== 16'd6 || ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: dout=%0d ovf=%b required 6/0", $signed(d2), ovf2); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [31:0] got[$];
    or0 = 1'b0;
    send0(8'd1, 8'd1, 1'b1, 1'b1);
    send0(8'd2, 8'd1, 1'b1, 1'b1);
    send0(8'd3, 8'd1, 1'b1, 1'b1);
    wait_ov0(cyc);
    n_checks++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL bp_first_result: out_valid=%b required 1", ov0); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (r0 !== 1'b0 || ov0 !== 1'b1 || d0 !== 32'd1) begin
        n_fail++;
        $display("FAIL bp_hold: in_ready=%b valid=%b dout=%0d required 0/1/1", r0, ov0, d0);
      end
    end
    @(posedge clk); #1;
    or0 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov0 && or0) begin
        got.push_back(d0);
        $display("bp result: dout=%0d", d0);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d results required 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_checks++;
      if (got[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL bp_order: result %0d is %0d required %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_mid_first();
    int cyc;
    or0 = 1'b1;
    send0(8'd7, 8'd9, 1'b1, 1'b0);
    send0(8'd4, 8'd4, 1'b0, 1'b0);
    send0(8'd3, 8'd5, 1'b1, 1'b1);
    wait_ov0(cyc);
    n_checks++; if (ov0 !== 1'b1 || d0 !== 32'd15) begin n_fail++; $display("FAIL mid_first: valid=%b dout=%0d required 1/15", ov0, $signed(d0)); end
    $display("mid first: dout=%0d", $signed(d0));
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int stale;
    or0 = 1'b1;
    send0(8'd9, 8'd9, 1'b1, 1'b0);
    send0(8'd9, 8'd9, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ov0 !== 1'b0 || d0 !== 32'd0 || r0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: valid=%b dout=%0d ready=%b required 0/0/1", ov0, d0, r0); end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rstmid_stale: %0d cycles with out_valid, required 0", stale); end
    @(posedge clk); #1;
    send0(8'd1, 8'd1, 1'b0, 1'b1);
    wait_ov0(cyc);
    n_checks++; if (ov0 !== 1'b1 || d0 !== 32'd1) begin n_fail++; $display("FAIL rstmid_fresh: valid=%b dout=%0d required 1/1", ov0, $signed(d0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    longint      acc_m, p, s;
    bit          idle_m, ovf_m, stalled, accepted;
    logic [31:0] held_d;
    logic        held_o;
    logic [31:0] exp_d[$];
    bit          exp_o[$];
    int          n_out;
    idle_m = 1; ovf_m = 0; acc_m = 0; stalled = 0; n_out = 0;
    held_d = '0; held_o = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        if (!v0 && $urandom_range(3) != 0) begin
          v0 = 1'b1;
          a0 = 8'($urandom);
          b0 = 8'($urandom);
          f0 = ($urandom_range(3) == 0);
          l0 = ($urandom_range(2) == 0);
        end
        or0 = ($urandom_range(3) != 0);
      end else begin
        or0 = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (r0 !== !(ov0 && !or0)) begin n_fail++; $display("FAIL rnd_ready: in_ready=%b valid=%b out_ready=%b", r0, ov0, or0); end
      if (stalled) begin
        n_checks++;
        if (d0 !== held_d || ovf0 !== held_o) begin n_fail++; $display("FAIL rnd_stable: dout=%0h ovf=%b required %0h/%b", d0, ovf0, held_d, held_o); end
      end
      if (ov0 && or0) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: unexpected dout=%0d", $signed(d0));
        end else begin
          if (d0 !== exp_d[0] || ovf0 !== exp_o[0]) begin
            n_fail++; $display("FAIL rnd_result: dout=%0d ovf=%b required %0d/%b", $signed(d0), ovf0, $signed(exp_d[0]), exp_o[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_o.pop_front());
        end
        n_out++;
        $display("rnd result %0d: dout=%0d ovf=%0b", n_out, $signed(d0), ovf0);
      end
      stalled = ov0 && !or0;
      held_d = d0;
      held_o = ovf0;
      accepted = v0 && r0;
      if (accepted) begin
        p = longint'(a0) * longint'($signed(b0));
        if (f0 || idle_m) begin
          acc_m = p;
          ovf_m = 0;
        end else begin
          s = acc_m + p;
          if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf_m = 1;
          acc_m = longint'($signed(s[31:0]));
        end
        if (l0) begin
          exp_d.push_back(acc_m[31:0]);
          exp_o.push_back(ovf_m);
        end
        idle_m = l0;
      end
      @(posedge clk); #1;
      if (accepted) begin
        v0 = 1'b0; f0 = 1'b0; l0 = 1'b0;
      end
    end
    n_checks++;
    if (exp_d.size() !== 0) begin n_fail++; $display("FAIL rnd_lost: %0d results never emerged, required 0", exp_d.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; a0 = 0; b0 = 0; f0 = 0; l0 = 0; or0 = 1;
    v1 = 0; a1 = 0; b1 = 0; f1 = 0; l1 = 0; or1 = 1;
    v2 = 0; a2 = 0; b2 = 0; f2 = 0; l2 = 0; or2 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_group4();
    test_unsigned();
    test_overflow();
    test_backpressure();
    test_mid_first();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
